// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  start;
    logic                  byteValid;
    logic [7:0]            byteData;
    logic                  byteReady;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [31:0]           memWData;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, byteValid, byteData,
        input  byteReady, memWe, memAddr, memWData, busy, done, err
    );

    modport slave (
        input  start, byteValid, byteData,
        output byteReady, memWe, memAddr, memWData, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed little-endian word image into instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module imem_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WIDTH  = 10
) (
    input logic           clk,
    input logic           rst,
    imem_loader_if.slave  bus_io
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE} state_t;
    localparam state_t FIN = CHK;
`else
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE} state_t;
    localparam state_t FIN = DONE;
`endif

    // Number of words that fit in memory; words past this are swallowed
    localparam logic [16:0] CAP = 17'(1) << MEM_WIDTH;

    state_t                state_q, state_d;
    logic [7:0]            nlo_q, nlo_d;
    logic [15:0]           n_q, n_d;
    logic [15:0]           wcnt_q, wcnt_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           asm_q, asm_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif
    logic                  busy;
    logic                  acc;
    logic [15:0]           n_new;
    logic [31:0]           word;

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign acc       = bus_io.byteValid && busy;
    assign n_new     = {bus_io.byteData, nlo_q};
    assign word      = {bus_io.byteData, asm_q};

    assign bus_io.byteReady = busy;
    assign bus_io.busy      = busy;
    assign bus_io.done      = (state_q == DONE);
    assign bus_io.err       = err_q;
    assign bus_io.memWe     = we_q;
    assign bus_io.memAddr   = addr_q;
    assign bus_io.memWData  = wdata_q;

    // Next-state logic: header capture, word assembly, write strobe and completion
    always_comb begin
        state_d = state_q;
        nlo_d   = nlo_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus_io.start) begin
                    state_d = LEN0;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            LEN0: begin
                if (acc) begin
                    nlo_d   = bus_io.byteData;
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (acc) begin
                    n_d     = n_new;
                    err_d   = ({1'b0, n_new} > CAP);
                    state_d = (n_new == 16'd0) ? FIN : DATA;
                end
            end
            DATA: begin
                if (acc) begin
                    asm_d  = {bus_io.byteData, asm_q[23:8]};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ bus_io.byteData;
`endif
                    if (bcnt_q == 2'd3) begin
                        // Only in-range words reach memory; the rest are consumed silently
                        if ({1'b0, wcnt_q} < CAP) begin
                            we_d    = 1'b1;
                            wdata_d = word;
                            addr_d  = ADDR_WIDTH'({wcnt_q, 2'b00});
                        end
                        wcnt_d  = wcnt_q + 16'd1;
                        state_d = (wcnt_q == n_q - 16'd1) ? FIN : DATA;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (acc) begin
                    err_d   = err_q | (bus_io.byteData != chk_q);
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            nlo_q   <= '0;
            n_q     <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            nlo_q   <= nlo_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed sessions checked against a stream-level model of the loader
module tb_imem_loader;
    localparam int MW = 2;
    localparam int CAPW = 1 << MW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(32)) bus ();

    imem_loader #(.ADDR_WIDTH(32), .MEM_WIDTH(MW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int total = 0;
    int bad = 0;

    logic [7:0]  stream [$];
    logic [31:0] exp_a [$];
    logic [31:0] exp_d [$];
    logic [31:0] obs_a [$];
    logic [31:0] obs_d [$];
    logic [31:0] w [8];
    logic        exp_err;

    // Record every write strobe seen on the memory bus
    always @(negedge clk) begin
        if (bus.memWe) begin
            obs_a.push_back(bus.memAddr);
            obs_d.push_back(bus.memWData);
        end
    end

    // Model: byte stream and resulting memory writes for n words from w[]
    task automatic build(input int n, input bit chk_bad);
        logic [7:0] x;
        logic [15:0] nn;
        x = 8'h00;
        nn = 16'(n);
        stream.delete();
        exp_a.delete();
        exp_d.delete();
        obs_a.delete();
        obs_d.delete();
        stream.push_back(nn[7:0]);
        stream.push_back(nn[15:8]);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                stream.push_back(w[i][8*b +: 8]);
                x = x ^ w[i][8*b +: 8];
            end
            if (i < CAPW) begin
                exp_a.push_back(32'(i * 4));
                exp_d.push_back(w[i]);
            end
        end
        exp_err = (n > CAPW);
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(chk_bad ? (x ^ 8'h01) : x);
        exp_err = exp_err | chk_bad;
`else
        if (chk_bad) exp_err = exp_err;
`endif
    endtask

    // Pulse start then offer the stream; mode 0 continuous, 1 toggled valid, 2 random valid and stray starts
    task automatic drive(input int mode);
        int i;
        int cyc;
        logic v;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        i = 0;
        cyc = 0;
        while (i < stream.size() && cyc < 2000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.byteValid = v;
            bus.byteData = stream[i];
            #1;
            if (v && bus.byteReady) i++;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.byteValid = 1'b0;
        if (i < stream.size()) begin
            total++;
            bad++;
            $display("FAIL stream_timeout: accepted %0d bytes, required %0d", i, stream.size());
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.byteValid = 1'b0;
        bus.byteData = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.byteReady, bus.memWe, bus.busy, bus.done, bus.err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b, required 00000", {bus.byteReady, bus.memWe, bus.busy, bus.done, bus.err});
        end
        total++;
        if ({bus.memAddr, bus.memWData} !== 64'h0) begin
            bad++;
            $display("FAIL reset_bus: got addr %h data %h, required 0", bus.memAddr, bus.memWData);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy %b done %b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        int rows;
`ifdef IMEM_LOADER_CHECKSUM_EN
        rows = 5;
`else
        rows = 4;
`endif
        for (int r = 0; r < rows; r++) begin
            w[0] = 32'h0000_0013;
            w[1] = 32'h0000_006F;
            for (int k = 2; k < 8; k++) w[k] = $urandom;
            if (r == 3) for (int k = 0; k < 8; k++) w[k] = $urandom;
            build((r == 1) ? 0 : (r == 3) ? 5 : 2, r == 4);
            drive((r == 2) ? 1 : 0);
            total++;
            if (bus.done !== 1'b1) begin
                bad++;
                $display("FAIL dir%0d_done: got %b, required 1", r, bus.done);
            end
            total++;
            if (bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_busy: got %b, required 0", r, bus.busy);
            end
            total++;
            if (bus.err !== exp_err) begin
                bad++;
                $display("FAIL dir%0d_err: got %b, required %b", r, bus.err, exp_err);
            end
            repeat (2) @(negedge clk);
            total++;
            if (obs_a.size() != exp_a.size()) begin
                bad++;
                $display("FAIL dir%0d_writes: got %0d, required %0d", r, obs_a.size(), exp_a.size());
            end else begin
                foreach (exp_a[k]) begin
                    total++;
                    if (obs_a[k] !== exp_a[k] || obs_d[k] !== exp_d[k]) begin
                        bad++;
                        $display("FAIL dir%0d_write%0d: got %h/%h, required %h/%h", r, k, obs_a[k], obs_d[k], exp_a[k], exp_d[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 8; k++) w[k] = $urandom;
            build($urandom_range(0, 7), 1'($urandom_range(0, 1)));
            drive(2);
            total++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL rnd%0d_done: done %b busy %b, required 1 0", r, bus.done, bus.busy);
            end
            total++;
            if (bus.err !== exp_err) begin
                bad++;
                $display("FAIL rnd%0d_err: got %b, required %b", r, bus.err, exp_err);
            end
            repeat (2) @(negedge clk);
            total++;
            if (obs_a.size() != exp_a.size()) begin
                bad++;
                $display("FAIL rnd%0d_writes: got %0d, required %0d", r, obs_a.size(), exp_a.size());
            end else begin
                foreach (exp_a[k]) begin
                    total++;
                    if (obs_a[k] !== exp_a[k] || obs_d[k] !== exp_d[k]) begin
                        bad++;
                        $display("FAIL rnd%0d_write%0d: got %h/%h, required %h/%h", r, k, obs_a[k], obs_d[k], exp_a[k], exp_d[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        w[0] = 32'h0000_0013;
        w[1] = 32'h0000_006F;
        build(2, 1'b0);
        while (stream.size() > 6) void'(stream.pop_back());
        drive(0);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (obs_a.size() != 1) begin
            bad++;
            $display("FAIL midrst_first_write: got %0d writes, required 1", obs_a.size());
        end
        total++;
        if ({bus.byteReady, bus.memWe, bus.busy, bus.done, bus.err} !== 5'b0 || {bus.memAddr, bus.memWData} !== 64'h0) begin
            bad++;
            $display("FAIL midrst_outputs: flags %b addr %h data %h, required all 0",
                     {bus.byteReady, bus.memWe, bus.busy, bus.done, bus.err}, bus.memAddr, bus.memWData);
        end
        obs_a.delete();
        obs_d.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.byteValid = 1'b1;
            bus.byteData = 8'($urandom);
            @(negedge clk);
        end
        bus.byteValid = 1'b0;
        total++;
        if (obs_a.size() != 0) begin
            bad++;
            $display("FAIL midrst_no_write: got %0d writes, required 0", obs_a.size());
        end
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.byteReady !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle: busy %b done %b ready %b, required 0 0 0", bus.busy, bus.done, bus.byteReady);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
